audio_mixer: RTL and testbench
==============================

AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 Parameter CH, default 8, channel count, legal range 2..16.
REQ-002 Parameter IW, default 12, unsigned sample width per channel.
REQ-003 Parameter GW, default 4, per-channel gain width.
REQ-004 Parameter SHIFT, default 2, right shift applied to the accumulator before output saturation.
REQ-005 Parameter OW, default 15, output width.
REQ-006 clock  in  1  single block clock; all state SHALL change on its rising edge only.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 ce  in  1  sample strobe; starts one mix pass.
REQ-009 din  in  CH*IW  flat unsigned samples; channel k SHALL occupy din[k*IW +: IW].
REQ-010 we  in  1  control register write enable.
REQ-011 wa  in  4  channel address for a write.
REQ-012 wd  in  8  write data: [GW-1:0] gain, [5:4] pan (00 both, 01 left only, 10 right only, 11 mute).
REQ-013 busy  out  1  high while a mix pass is in progress.
REQ-014 left  out  OW  mixed left output, unsigned.
REQ-015 right  out  OW  mixed right output, unsigned.
REQ-016 valid  out  1  one-cycle pulse when left/right update.

Function
REQ-017 States SHALL be IDLE, ACC and DONE.
REQ-018 IDLE + ce: capture din and all gain/pan registers into snapshot registers, clear both accumulators, set index 0, go to ACC.
REQ-019 ACC: each cycle, product = sample[index] * gain[index] (IW+GW bits) SHALL be added to left and/or right per pan[index]; mute adds nothing.
REQ-020 ACC: after index CH-1 is processed, go to DONE; otherwise increment index.
REQ-021 Accumulator width SHALL be IW+GW+clog2(CH) bits, so no wrap-around occurs.
REQ-022 DONE: left/right = min(acc >> SHIFT, 2^OW-1); valid pulses for that one cycle; return to IDLE.
REQ-023 Latency: ce sampled at edge t; valid and new outputs SHALL appear at edge t+CH+1.
REQ-024 busy SHALL be high from edge t+1 through the DONE cycle inclusive.
REQ-025 ce while busy SHALL be ignored and not queued; ce in the DONE cycle SHALL also be ignored.
REQ-026 left/right SHALL hold their value between valid pulses.
REQ-027 Writes SHALL be accepted in any state; those during ACC/DONE affect only the next pass (snapshot rule).
REQ-028 Writes with wa >= CH SHALL be ignored.

Reset
REQ-029 On reset low at a clock edge: state IDLE, busy 0, valid 0, left 0, right 0, accumulators 0, index 0.
REQ-030 Reset SHALL set every gain to all-ones and every pan to 00.
REQ-031 Reset during ACC SHALL abort the pass; no valid pulse for it.
REQ-032 Reset SHALL take priority over ce and we in the same cycle.

Configuration
REQ-033 Macro AUDIO_MIXER_PAN_EN defined: pan registers and wd[5:4] SHALL behave as REQ-012/REQ-019.
REQ-034 Macro absent: pan registers SHALL not exist, wd[5:4] SHALL be ignored, every channel SHALL add to both sides.

Verification
REQ-035 After reset, din ch0=0xFFF, others 0, ce pulse -> valid at t+9, left=right=15356 (61425>>2).
REQ-036 All 8 channels 0xFFF, default gains, ce -> left=right=32767 (122850 saturated).
REQ-037 Macro on, write wa=1 wd=0x1F, ch1=0x100, others 0, ce -> left=960, right=0; macro off -> left=right=960.
REQ-038 ce at t, second ce at t+3, and a write of wa=0 wd=0x00 at t+2 -> single valid, current result unchanged; next pass with ch0=0xFFF and other channels 0 gives left=right=0.
REQ-039 Reset low at t+4 of a pass -> no valid, outputs 0, busy 0; next pass uses gain 0xF.
REQ-040 Write wa=9 wd=0x00, then all channels 0xFFF and ce -> result equals REQ-036 (write ignored).

Source files
------------

// File: rtl/audio_mixer.sv
// audio_mixer: sequential CH-channel gain/pan mixer with saturated stereo output
// Optional feature macro AUDIO_MIXER_PAN_EN: per-channel pan from wd[5:4]; without it every channel feeds both sides.
module audio_mixer #(
    parameter int CH    = 8,
    parameter int IW    = 12,
    parameter int GW    = 4,
    parameter int SHIFT = 2,
    parameter int OW    = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [CH*IW-1:0] din,
    input  logic             we,
    input  logic [3:0]       wa,
    input  logic [7:0]       wd,
    output logic             busy,
    output logic [OW-1:0]    left,
    output logic [OW-1:0]    right,
    output logic             valid
);
    localparam int XW = $clog2(CH);
    localparam int PW = IW + GW;
    localparam int AW = PW + XW;
    localparam int SW = AW > OW ? AW : OW;
    localparam logic [SW-1:0] MAXV = SW'({OW{1'b1}});
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [XW-1:0]    idx;
    logic [GW-1:0]    gain [CH];
    logic [GW-1:0]    s_gain [CH];
    logic [CH*IW-1:0] s_din;
    logic [AW-1:0]    acc_l;
    logic [AW-1:0]    acc_r;
    logic [IW-1:0]    cur_s;
    logic [PW-1:0]    prod;
    logic             add_l;
    logic             add_r;
    logic [SW-1:0]    sh_l;
    logic [SW-1:0]    sh_r;
    logic             unused;
`ifdef AUDIO_MIXER_PAN_EN
    logic [1:0]       pan [CH];
    logic [1:0]       s_pan [CH];
`endif

    assign busy   = state != IDLE;
    assign unused = ^wd[7:GW];

    // current channel product, pan routing and shifted accumulators for saturation
    always_comb begin
        cur_s = s_din[int'(idx)*IW +: IW];
        prod  = PW'(cur_s) * PW'(s_gain[idx]);
`ifdef AUDIO_MIXER_PAN_EN
        add_l = ~s_pan[idx][1];
        add_r = ~s_pan[idx][0];
`else
        add_l = 1'b1;
        add_r = 1'b1;
`endif
        sh_l  = SW'(acc_l >> SHIFT);
        sh_r  = SW'(acc_r >> SHIFT);
    end

    // control registers: writes land in any state, reset restores full gain and centre pan
    always_ff @(posedge clock) begin
        for (int k = 0; k < CH; k++) begin
            if (!reset) begin
                gain[k] <= '1;
`ifdef AUDIO_MIXER_PAN_EN
                pan[k]  <= 2'b00;
`endif
            end else if (we && wa == 4'(k)) begin
                gain[k] <= wd[GW-1:0];
`ifdef AUDIO_MIXER_PAN_EN
                pan[k]  <= wd[5:4];
`endif
            end
        end
    end

    // snapshot of samples and settings taken when a pass starts, so later writes only affect the next pass
    always_ff @(posedge clock) begin
        if (reset && state == IDLE && ce) begin
            s_din  <= din;
            s_gain <= gain;
`ifdef AUDIO_MIXER_PAN_EN
            s_pan  <= pan;
`endif
        end
    end

    // mix FSM: one channel per cycle in ACC, saturate and publish in DONE
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
            left  <= '0;
            right <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ce) begin
                        state <= ACC;
                        idx   <= '0;
                        acc_l <= '0;
                        acc_r <= '0;
                    end
                end
                ACC: begin
                    if (add_l) acc_l <= acc_l + AW'(prod);
                    if (add_r) acc_r <= acc_r + AW'(prod);
                    if (idx == XW'(CH - 1)) state <= DONE;
                    else idx <= idx + 1'b1;
                end
                DONE: begin
                    left  <= sh_l > MAXV ? {OW{1'b1}} : sh_l[OW-1:0];
                    right <= sh_r > MAXV ? {OW{1'b1}} : sh_r[OW-1:0];
                    valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: scoreboard bench for audio_mixer (default parameters, either pan build)
module tb_audio_mixer;
    localparam int CH = 8;
    localparam int IW = 12;
    localparam int GW = 4;
    localparam int OW = 15;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ce = 1'b0;
    logic             we = 1'b0;
    logic [CH*IW-1:0] din = '0;
    logic [3:0]       wa = '0;
    logic [7:0]       wd = '0;
    logic             busy;
    logic             valid;
    logic [OW-1:0]    left;
    logic [OW-1:0]    right;

    int checks = 0;
    int failures = 0;
    int vcount = 0;
    logic [2*OW-1:0] sb [$];

    audio_mixer #(.CH(CH), .IW(IW), .GW(GW), .SHIFT(2), .OW(OW)) dut (
        .clock(clock), .reset(reset), .ce(ce), .din(din), .we(we), .wa(wa), .wd(wd),
        .busy(busy), .left(left), .right(right), .valid(valid)
    );

    always #5 clock = ~clock;

    // scoreboard: every valid pulse must match the oldest expected result
    always @(negedge clock) begin
        logic [2*OW-1:0] exp;
        if (valid === 1'b1) begin
            vcount++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid left=%0d right=%0d expected=no pulse", left, right);
            end else begin
                exp = sb.pop_front();
                if ({left, right} !== exp) begin
                    failures++;
                    $display("FAIL mix_result left=%0d right=%0d expected_left=%0d expected_right=%0d",
                             left, right, exp[2*OW-1:OW], exp[OW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ce = 1'b0;
        we = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic run_pass(input logic [CH*IW-1:0] d, input logic [OW-1:0] el, input logic [OW-1:0] er);
        din = d;
        ce = 1'b1;
        sb.push_back({el, er});
        tick();
        ce = 1'b0;
        for (int i = 0; i < CH + 4 && valid !== 1'b1; i++) tick();
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL pass_timeout valid=%b expected=1", valid);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        din = {CH*IW{1'b1}};
        ce = 1'b1;
        we = 1'b1;
        wa = 4'd0;
        wd = 8'h00;
        tick();
        tick();
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", valid); end
        if (left !== '0) begin failures++; $display("FAIL reset_left got=%0d expected=0", left); end
        if (right !== '0) begin failures++; $display("FAIL reset_right got=%0d expected=0", right); end
        ce = 1'b0;
        we = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b expected=0", busy); end
    endtask

    task automatic test_latency();
        logic [CH*IW-1:0] d;
        int v0;
        d = '0;
        d[IW-1:0] = 12'hFFF;
        din = d;
        ce = 1'b1;
        sb.push_back({15'd15356, 15'd15356});
        tick();
        ce = 1'b0;
        v0 = vcount;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL latency_busy_start got=%b expected=1", busy); end
        for (int k = 1; k <= CH; k++) begin
            tick();
            checks += 2;
            if (valid !== 1'b0) begin failures++; $display("FAIL latency_early_valid edge=t+%0d got=%b expected=0", k, valid); end
            if (busy !== 1'b1) begin failures++; $display("FAIL latency_busy edge=t+%0d got=%b expected=1", k, busy); end
            if (k == CH) ce = 1'b1;
        end
        tick();
        ce = 1'b0;
        checks += 2;
        if (valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b expected=1", valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL latency_busy_end got=%b expected=0", busy); end
        tick();
        checks += 2;
        if (valid !== 1'b0) begin failures++; $display("FAIL valid_one_cycle got=%b expected=0", valid); end
        if (left !== 15'd15356) begin failures++; $display("FAIL output_hold got=%0d expected=15356", left); end
        repeat (CH + 2) tick();
        checks++;
        if (vcount !== v0 + 1) begin failures++; $display("FAIL done_ce_ignored pulses=%0d expected=%0d", vcount - v0, 1); end
    endtask

    task automatic test_saturate();
        run_pass({CH*IW{1'b1}}, 15'd32767, 15'd32767);
    endtask

    task automatic test_pan();
        logic [CH*IW-1:0] d;
        do_reset();
        write_reg(4'd1, 8'h1F);
        d = '0;
        d[IW +: IW] = 12'h100;
`ifdef AUDIO_MIXER_PAN_EN
        run_pass(d, 15'd960, 15'd0);
`else
        run_pass(d, 15'd960, 15'd960);
`endif
    endtask

    task automatic test_back_to_back();
        logic [CH*IW-1:0] d;
        int v0;
        do_reset();
        d = '0;
        d[IW-1:0] = 12'h100;
        din = d;
        ce = 1'b1;
        sb.push_back({15'd960, 15'd960});
        tick();
        ce = 1'b0;
        v0 = vcount;
        tick();
        we = 1'b1;
        wa = 4'd0;
        wd = 8'h00;
        tick();
        we = 1'b0;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b expected=1", busy); end
        for (int i = 0; i < CH + 4 && valid !== 1'b1; i++) tick();
        repeat (CH + 3) tick();
        checks++;
        if (vcount !== v0 + 1) begin failures++; $display("FAIL b2b_single_valid pulses=%0d expected=%0d", vcount - v0, 1); end
        d[IW-1:0] = 12'hFFF;
        run_pass(d, 15'd0, 15'd0);
    endtask

    task automatic test_reset_abort();
        logic [CH*IW-1:0] d;
        int v0;
        do_reset();
        write_reg(4'd0, 8'h03);
        d = '0;
        d[IW-1:0] = 12'hFFF;
        run_pass(d, 15'd3071, 15'd3071);
        din = d;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        v0 = vcount;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b expected=0", busy); end
        if (valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b expected=0", valid); end
        if (left !== '0) begin failures++; $display("FAIL abort_left got=%0d expected=0", left); end
        if (right !== '0) begin failures++; $display("FAIL abort_right got=%0d expected=0", right); end
        repeat (CH + 3) tick();
        checks++;
        if (vcount !== v0) begin failures++; $display("FAIL abort_no_valid pulses=%0d expected=0", vcount - v0); end
        run_pass(d, 15'd15356, 15'd15356);
    endtask

    task automatic test_bad_addr();
        do_reset();
        write_reg(4'd9, 8'h00);
        run_pass({CH*IW{1'b1}}, 15'd32767, 15'd32767);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_saturate();
        test_pan();
        test_back_to_back();
        test_reset_abort();
        test_bad_addr();
        tick();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
